flag_branch_unit: RTL

//  Sits directly downstream of the execute-stage ALU. Holds the architectural Z/V/N flag register.

---
 rtl/flag_branch_unit_pkg.sv | 56 +++++
 rtl/flag_branch_unit_cond_eval.sv | 41 ++++
 rtl/flag_branch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/flag_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flag_branch_unit_pkg
//  Description : Shared definitions for the flag/branch unit: ALU opcodes,
//                flag bit positions, branch condition codes, FSM states and
//                the per-opcode flag write-mask decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package flag_branch_unit_pkg;

  // ALU opcodes as seen in the EX stage
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADSUB = 3'b111;

  // Bit positions inside the {Z,V,N} flag vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Branch condition codes
  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_UN = 3'b111
  } cond_e;

  // Branch-resolution FSM state (one bit)
  typedef logic [0:0] state_t;
  localparam state_t ST_EVAL = 1'b0;
  localparam state_t ST_HOLD = 1'b1;

  // Which flags an opcode is allowed to overwrite
  function automatic logic [2:0] write_mask(input logic [2:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flag_branch_unit_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : flag_branch_unit_cond_eval
//  Description : Purely combinational branch condition evaluator. Maps a
//                {Z,V,N} flag vector and a 3-bit condition code to taken.
//  Revision    : 1.0  initial release
// ============================================================================
module flag_branch_unit_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] flags_i,
  input  logic [2:0] cond_i,
  output logic       taken_o
);

  logic z;
  logic v;
  logic n;

  assign z = flags_i[FLAG_Z];
  assign v = flags_i[FLAG_V];
  assign n = flags_i[FLAG_N];

  // Condition table lookup
  always_comb begin
    taken_o = 1'b0;
    case (cond_e'(cond_i))
      COND_NE: taken_o = !z;
      COND_EQ: taken_o = z;
      COND_GT: taken_o = !z && !n;
      COND_LT: taken_o = n;
      COND_GE: taken_o = z || !n;
      COND_LE: taken_o = z || n;
      COND_OV: taken_o = v;
      COND_UN: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : flag_branch_unit
//  Description : Architectural Z/V/N flag register fed by the EX-stage ALU,
//                plus decode-stage conditional branch resolution. With
//                BYPASS=0 a branch whose flags are still being produced in
//                EX is held for one cycle; with BYPASS=1 the freshly merged
//                flags are forwarded combinationally instead.
//  Revision    : 1.0  initial release
// ============================================================================
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int BYPASS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       ex_valid,
  input  logic [2:0] ex_opcode,
  input  logic [2:0] ex_flags,
  input  logic       id_is_branch,
  input  logic [2:0] id_cond,
  output logic [2:0] flags_out,
  output logic       branch_stall,
  output logic       branch_valid,
  output logic       branch_taken
);

  logic [2:0] flags_q;
  logic [2:0] flags_d;
  state_t     state_q;
  state_t     state_d;

  logic [2:0] ex_mask;
  logic       ex_writes;
  logic [2:0] flags_merged;
  logic [2:0] cond_flags;
  logic       cond_taken;
  logic       stall_c;
  logic       valid_c;

  assign ex_mask      = write_mask(ex_opcode);
  assign ex_writes    = ex_valid && (ex_mask != 3'b000);
  assign flags_merged = (flags_q & ~ex_mask) | (ex_flags & ex_mask);

  // Masked flag write; a global stall or a bubble leaves the flags alone
  always_comb begin
    flags_d = flags_q;
    if (ex_valid && !stall) begin
      flags_d = flags_merged;
    end
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      // Forward the merged result so the branch never sees stale flags
      assign cond_flags = ex_writes ? flags_merged : flags_q;

      // No waiting: FSM parked in EVAL, branch resolves immediately
      always_comb begin
        state_d = ST_EVAL;
        stall_c = 1'b0;
        valid_c = id_is_branch;
      end
    end else begin : g_stall
      // Branch only ever looks at the committed flag register
      assign cond_flags = flags_q;

      // EVAL/HOLD sequencing: wait one cycle when EX is about to write flags
      always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        valid_c = 1'b0;
        case (state_q)
          ST_EVAL: begin
            if (id_is_branch) begin
              if (ex_writes) begin
                stall_c = 1'b1;
                if (!stall) begin
                  state_d = ST_HOLD;
                end
              end else begin
                valid_c = 1'b1;
              end
            end
          end
          ST_HOLD: begin
            // A dropped id_is_branch here is a flush: return without resolving
            valid_c = id_is_branch;
            if (!stall) begin
              state_d = ST_EVAL;
            end
          end
          default: state_d = ST_EVAL;
        endcase
      end
    end
  endgenerate

  flag_branch_unit_cond_eval u_cond_eval (
    .flags_i (cond_flags),
    .cond_i  (id_cond),
    .taken_o (cond_taken)
  );

  // Suppress branch outputs while reset is applied so an aborted branch never resolves
  assign branch_stall = stall_c && !rst;
  assign branch_valid = valid_c && !rst;
  assign branch_taken = valid_c && cond_taken && !rst;
  assign flags_out    = flags_q;

  // Flag register and FSM state; global stall freezes both
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
      state_q <= ST_EVAL;
    end else if (!stall) begin
      flags_q <= flags_d;
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire
